// File: rtl/sop_pkg.sv
// ---------------------------------------------------------------------------
// sop_pkg
// Shared definitions for the truth-table scanner.
//   SETTLE_MAX   : largest legal settle wait per row
//   N_IN_MAX     : largest legal number of scanned inputs
//   SETTLE_CNT_W : width of the settle counter, sized to hold SETTLE_MAX
//   scan_state_t : scanner FSM states
// ---------------------------------------------------------------------------
package sop_pkg;

    localparam int SETTLE_MAX   = 15;
    localparam int N_IN_MAX     = 4;
    localparam int SETTLE_CNT_W = $clog2(SETTLE_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } scan_state_t;

endpackage

// File: rtl/sop_settle_timer.sv
// ---------------------------------------------------------------------------
// sop_settle_timer
// Counts the wait cycles spent on one truth-table row before sampling.
// Ports:
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   i_clear   : restart the count at zero on the next edge
//   i_enable  : advance the count while not yet expired
//   o_expired : high once SETTLE cycles have elapsed since the last clear
// ---------------------------------------------------------------------------
module sop_settle_timer
    import sop_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [SETTLE_CNT_W-1:0] LAST_COUNT = SETTLE_CNT_W'(SETTLE - 1);

    logic [SETTLE_CNT_W-1:0] r_count;

    // The counter holds at its last value once expired, so expired stays
    // asserted for the cycle in which the FSM leaves the settle state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + SETTLE_CNT_W'(1);
        end
    end

    // Count 0 is the first settle cycle, so SETTLE-1 marks the last one.
    assign o_expired = (r_count == LAST_COUNT);

endmodule

// File: rtl/sop_table_scanner.sv
// ---------------------------------------------------------------------------
// sop_table_scanner
// Walks every input code of a small combinational device, waits SETTLE
// cycles per code, samples the response and builds its truth table.
// Ports:
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   i_start    : begin a full scan (ignored while busy)
//   i_resp     : response F of the device under scan
//   i_expected : expected minterm mask, bit i = F for code i
//   o_stim     : input code driven to the device, MSB = A
//   o_busy     : scan in progress
//   o_done     : scan finished, results valid
//   o_minterms : captured truth table, bit i = sampled response for code i
//   o_count    : number of true minterms
//   o_pass     : captured table matches i_expected (only while done)
// ---------------------------------------------------------------------------
module sop_table_scanner
    import sop_pkg::*;
#(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic                 i_resp,
    input  logic [2**N_IN-1:0]   i_expected,
    output logic [N_IN-1:0]      o_stim,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [2**N_IN-1:0]   o_minterms,
    output logic [N_IN:0]        o_count,
    output logic                 o_pass
);

    localparam int              N_CODES   = 2**N_IN;
    localparam logic [N_IN-1:0] LAST_CODE = '1;

    scan_state_t        r_state;
    scan_state_t        w_nextState;
    logic [N_IN-1:0]    r_stim;
    logic [N_CODES-1:0] r_minterms;
    logic [N_IN:0]      r_count;
    logic               w_accept;
    logic               w_lastCode;
    logic               w_expired;
    logic               w_timerClear;
    logic               w_timerEnable;

    // A start is only honoured from the resting states; while busy it is ignored.
    assign w_accept   = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && i_start;
    assign w_lastCode = (r_stim == LAST_CODE);

    sop_settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_timerClear),
        .i_enable  (w_timerEnable),
        .o_expired (w_expired)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: each row is SETTLE wait cycles followed by one sample
    // cycle; the final row drops into DONE instead of advancing the code.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    w_nextState = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (w_expired) begin
                    w_nextState = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                w_nextState = w_lastCode ? ST_DONE : ST_SETTLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Output logic: status flags and settle-timer control decoded from state.
    // The timer restarts on every accepted start and after every sample so
    // each row sees a fresh wait.
    always_comb begin
        o_busy        = 1'b0;
        o_done        = 1'b0;
        w_timerEnable = 1'b0;
        w_timerClear  = w_accept;
        case (r_state)
            ST_SETTLE: begin
                o_busy        = 1'b1;
                w_timerEnable = 1'b1;
            end
            ST_SAMPLE: begin
                o_busy       = 1'b1;
                w_timerClear = 1'b1;
            end
            ST_DONE: begin
                o_done = 1'b1;
            end
            default: begin
                o_busy = 1'b0;
            end
        endcase
        o_pass = o_done && (r_minterms == i_expected);
    end

    // Scan datapath: clear everything on an accepted start, capture the
    // response only in the sample cycle, and hold the last code at the end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stim     <= '0;
            r_minterms <= '0;
            r_count    <= '0;
        end else if (w_accept) begin
            r_stim     <= '0;
            r_minterms <= '0;
            r_count    <= '0;
        end else if (r_state == ST_SAMPLE) begin
            r_minterms[r_stim] <= i_resp;
            r_count            <= r_count + (N_IN + 1)'(i_resp);
            if (!w_lastCode) begin
                r_stim <= r_stim + N_IN'(1);
            end
        end
    end

    assign o_stim     = r_stim;
    assign o_minterms = r_minterms;
    assign o_count    = r_count;

endmodule

// File: tb/tb_sop_table_scanner.sv
// ---------------------------------------------------------------------------
// tb_sop_table_scanner
// Drives two scanner instances (N_IN=2/SETTLE=1 and N_IN=3/SETTLE=2) with
// known logic functions and compares the captured truth tables, counts,
// pass flags and completion latency against hand-derived values.
// Edges are numbered with the edge that accepts start as edge 1.
// ---------------------------------------------------------------------------
module tb_sop_table_scanner;

    typedef struct {
        int         sel;
        logic [3:0] expMask;
        logic [3:0] minterms;
        logic [2:0] count;
        logic       pass;
    } vec_t;

    typedef struct {
        logic [7:0] minterms;
        logic [3:0] count;
        logic       pass;
        int         latency;
    } sb_t;

    logic       clk;
    logic       rst2, rst3;
    logic       start2, start3;
    logic       resp2, resp3;
    logic [3:0] expected2;
    logic [7:0] expected3;
    logic [1:0] stim2;
    logic [2:0] stim3;
    logic       busy2, busy3, done2, done3, pass2, pass3;
    logic [3:0] minterms2;
    logic [7:0] minterms3;
    logic [2:0] count2;
    logic [3:0] count3;

    int   sel2;
    int   activeDut;
    logic glitchMode;
    logic glitchVal;

    int checks;
    int failures;

    sb_t  sbQueue[$];
    vec_t vecs[7];

    logic       obsDone, obsBusy, obsPass;
    logic [7:0] obsMinterms;
    logic [3:0] obsCount;

    // Reference functions of the devices under scan; stim bit MSB is A.
    function automatic logic f2(input int sel, input logic [1:0] s);
        case (sel)
            0:       return s[1] ^ s[0];
            1:       return s[1] & s[0];
            2:       return s[1] | s[0];
            3:       return ~(s[1] & s[0]);
            4:       return 1'b0;
            5:       return 1'b1;
            default: return s[1];
        endcase
    endfunction

    function automatic logic maj3(input logic [2:0] s);
        return (s[2] & s[1]) | (s[2] & s[0]) | (s[1] & s[0]);
    endfunction

    function automatic sb_t mkRec(input logic [7:0] m, input logic [3:0] c,
                                  input logic p, input int lat);
        sb_t r;
        r.minterms = m;
        r.count    = c;
        r.pass     = p;
        r.latency  = lat;
        return r;
    endfunction

    assign resp2 = f2(sel2, stim2);
    assign resp3 = glitchMode ? glitchVal : maj3(stim3);

    // Observed outputs of whichever instance the current scan targets.
    assign obsDone     = (activeDut == 3) ? done3 : done2;
    assign obsBusy     = (activeDut == 3) ? busy3 : busy2;
    assign obsPass     = (activeDut == 3) ? pass3 : pass2;
    assign obsMinterms = (activeDut == 3) ? minterms3 : {4'b0000, minterms2};
    assign obsCount    = (activeDut == 3) ? count3 : {1'b0, count2};

    sop_table_scanner #(.N_IN(2), .SETTLE(1)) dut2 (
        .clk        (clk),
        .rst_n      (rst2),
        .i_start    (start2),
        .i_resp     (resp2),
        .i_expected (expected2),
        .o_stim     (stim2),
        .o_busy     (busy2),
        .o_done     (done2),
        .o_minterms (minterms2),
        .o_count    (count2),
        .o_pass     (pass2)
    );

    sop_table_scanner #(.N_IN(3), .SETTLE(2)) dut3 (
        .clk        (clk),
        .rst_n      (rst3),
        .i_start    (start3),
        .i_resp     (resp3),
        .i_expected (expected3),
        .o_stim     (stim3),
        .o_busy     (busy3),
        .o_done     (done3),
        .o_minterms (minterms3),
        .o_count    (count3),
        .o_pass     (pass3)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic setStart(input int dutSel, input logic v);
        if (dutSel == 3) start3 = v;
        else             start2 = v;
    endtask

    // Glitch mode for the N_IN=3/SETTLE=2 instance: the response is inverted
    // during both settle cycles of a row and correct only in the sample cycle.
    task automatic updateGlitch(input int edgeNum);
        int phase;
        phase = (edgeNum - 1) % 3;
        if (phase < 2) glitchVal = ~maj3(stim3);
        else           glitchVal = maj3(stim3);
    endtask

    task automatic checkOutput(input int latency);
        sb_t rec;
        if (sbQueue.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL scoreboard_empty actual=0 required=1");
        end else begin
            rec = sbQueue.pop_front();
            checkVal("minterms", obsMinterms, rec.minterms);
            checkVal("count", obsCount, rec.count);
            checkVal("pass", obsPass, rec.pass);
            checkVal("done_latency", latency, rec.latency);
            checkVal("busy_at_done", obsBusy, 1'b0);
        end
    endtask

    task automatic applyStimulus(input int dutSel, input logic [7:0] expMask,
                                 input sb_t rec, input bit holdStart, input bit glitch);
        int  edgeNum;
        bit  seenDone;
        bit  busyHeld;
        activeDut = dutSel;
        if (dutSel == 3) expected3 = expMask;
        else             expected2 = expMask[3:0];
        sbQueue.push_back(rec);
        @(negedge clk);
        glitchMode = glitch;
        setStart(dutSel, 1'b1);
        @(posedge clk);
        #1;
        edgeNum = 1;
        if (!holdStart) setStart(dutSel, 1'b0);
        if (glitch) updateGlitch(edgeNum);
        checkVal("cleared_minterms", obsMinterms, 8'h00);
        checkVal("cleared_count", obsCount, 4'd0);
        checkVal("cleared_done", obsDone, 1'b0);
        checkVal("cleared_pass", obsPass, 1'b0);
        seenDone = 1'b0;
        busyHeld = 1'b1;
        while (!seenDone && edgeNum < 400) begin
            if (!obsBusy) busyHeld = 1'b0;
            @(posedge clk);
            #1;
            edgeNum++;
            if (glitch) updateGlitch(edgeNum);
            if (obsDone) seenDone = 1'b1;
        end
        setStart(dutSel, 1'b0);
        glitchMode = 1'b0;
        checkVal("busy_during_scan", busyHeld, 1'b1);
        checkOutput(seenDone ? edgeNum : -1);
    endtask

    initial begin
        int waitCount;
        bit found;
        checks     = 0;
        failures   = 0;
        rst2       = 1'b0;
        rst3       = 1'b0;
        start2     = 1'b0;
        start3     = 1'b0;
        sel2       = 0;
        activeDut  = 2;
        glitchMode = 1'b0;
        glitchVal  = 1'b0;
        expected2  = 4'b0110;
        expected3  = 8'b11101000;

        // Single-function vectors for the 2-input instance.
        vecs[0] = '{0, 4'b0110, 4'b0110, 3'd2, 1'b1};
        vecs[1] = '{1, 4'b0110, 4'b1000, 3'd1, 1'b0};
        vecs[2] = '{2, 4'b1110, 4'b1110, 3'd3, 1'b1};
        vecs[3] = '{3, 4'b0111, 4'b0111, 3'd3, 1'b1};
        vecs[4] = '{4, 4'b0000, 4'b0000, 3'd0, 1'b1};
        vecs[5] = '{5, 4'b1110, 4'b1111, 3'd4, 1'b0};
        vecs[6] = '{6, 4'b1100, 4'b1100, 3'd2, 1'b1};

        // Outputs while reset is held.
        #23;
        checkVal("reset_stim2", stim2, 2'd0);
        checkVal("reset_busy2", busy2, 1'b0);
        checkVal("reset_done2", done2, 1'b0);
        checkVal("reset_minterms2", minterms2, 4'd0);
        checkVal("reset_count2", count2, 3'd0);
        checkVal("reset_pass2", pass2, 1'b0);
        checkVal("reset_busy3", busy3, 1'b0);
        checkVal("reset_done3", done3, 1'b0);
        checkVal("reset_minterms3", minterms3, 8'd0);
        @(negedge clk);
        rst2 = 1'b1;
        rst3 = 1'b1;
        repeat (2) @(negedge clk);
        checkVal("idle_busy2", busy2, 1'b0);

        // Table-driven scans; each rescan starts from DONE of the previous one.
        for (int i = 0; i < 7; i++) begin
            sel2 = vecs[i].sel;
            applyStimulus(2, {4'b0000, vecs[i].expMask},
                          mkRec({4'b0000, vecs[i].minterms}, {1'b0, vecs[i].count},
                                vecs[i].pass, 9),
                          1'b0, 1'b0);
        end

        // Pass tracks expected combinationally while done.
        sel2 = 0;
        applyStimulus(2, 8'h06, mkRec(8'h06, 4'd2, 1'b1, 9), 1'b0, 1'b0);
        expected2 = 4'b0000;
        #1;
        checkVal("pass_live_mismatch", pass2, 1'b0);
        expected2 = 4'b0110;
        #1;
        checkVal("pass_live_match", pass2, 1'b1);

        // Start held high across the whole scan: one scan only.
        sel2 = 0;
        applyStimulus(2, 8'h06, mkRec(8'h06, 4'd2, 1'b1, 9), 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checkVal("hold_done_stays", done2, 1'b1);
        checkVal("hold_busy_low", busy2, 1'b0);
        checkVal("hold_minterms_kept", minterms2, 4'b0110);
        // New start in DONE clears and rescans with a different function.
        sel2 = 1;
        applyStimulus(2, 8'h06, mkRec(8'h08, 4'd1, 1'b0, 9), 1'b0, 1'b0);

        // Reset pulsed mid-scan while stim == 2.
        sel2 = 0;
        expected2 = 4'b0110;
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        found = 1'b0;
        waitCount = 0;
        while (!found && waitCount < 50) begin
            @(posedge clk);
            #1;
            waitCount++;
            if (stim2 == 2'd2) found = 1'b1;
        end
        checkVal("reach_stim2", found, 1'b1);
        #3;
        rst2 = 1'b0;
        #1;
        checkVal("abort_stim", stim2, 2'd0);
        checkVal("abort_busy", busy2, 1'b0);
        checkVal("abort_done", done2, 1'b0);
        checkVal("abort_minterms", minterms2, 4'd0);
        checkVal("abort_count", count2, 3'd0);
        checkVal("abort_pass", pass2, 1'b0);
        #2;
        rst2 = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checkVal("post_abort_busy", busy2, 1'b0);
        checkVal("post_abort_done", done2, 1'b0);
        checkVal("post_abort_stim", stim2, 2'd0);
        checkVal("post_abort_minterms", minterms2, 4'd0);
        applyStimulus(2, 8'h06, mkRec(8'h06, 4'd2, 1'b1, 9), 1'b0, 1'b0);

        // Majority on the 3-input instance, then the same with settle glitches.
        applyStimulus(3, 8'b11101000, mkRec(8'b11101000, 4'd4, 1'b1, 25), 1'b0, 1'b0);
        applyStimulus(3, 8'b11101000, mkRec(8'b11101000, 4'd4, 1'b1, 25), 1'b0, 1'b1);

        checkVal("scoreboard_drained", sbQueue.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sop_table_scanner.md
SOP_TABLE_SCANNER -- requirements
Module: sop_table_scanner

Interface
REQ-001 Parameter N_IN, default 2: number of combinational inputs driven, legal range 1..4.
REQ-002 Parameter SETTLE, default 1: wait cycles per truth-table row before sampling, legal range 1..15.
REQ-003 Port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port start  input  1  request to begin a full truth-table scan.
REQ-006 Port resp  input  1  combinational response F of the device under scan.
REQ-007 Port expected  input  2**N_IN  expected minterm mask; bit i = F for input code i.
REQ-008 Port stim  output  N_IN  input code driven to the device under scan; bit N_IN-1 = A (MSB).
REQ-009 Port busy  output  1  high while a scan is in progress.
REQ-010 Port done  output  1  high from scan completion until the next accepted start or reset.
REQ-011 Port minterms  output  2**N_IN  captured truth table; bit i = sampled resp for stim == i.
REQ-012 Port count  output  N_IN+1  number of set bits in minterms (true minterms).
REQ-013 Port pass  output  1  minterms == expected; valid only while done is high, 0 otherwise.

Function
REQ-014 The FSM SHALL have the states IDLE, SETTLE, SAMPLE and DONE.
REQ-015 IDLE or DONE with start=1: next state SETTLE, stim=0, settle counter=0, minterms=0, count=0, done=0, pass=0.
REQ-016 SETTLE: the FSM SHALL remain for exactly SETTLE cycles with stim held stable, then go to SAMPLE.
REQ-017 SAMPLE: one cycle; at its closing edge resp SHALL be written to minterms[stim], and count SHALL increment if resp=1.
REQ-018 SAMPLE, stim < 2**N_IN-1: next state SETTLE, stim+1, settle counter cleared.
REQ-019 SAMPLE, stim == 2**N_IN-1: next state DONE; stim SHALL hold its last value and SHALL not wrap.
REQ-020 DONE: done=1; pass SHALL equal (minterms == expected), evaluated combinationally against the current expected.
REQ-021 busy SHALL be 1 exactly in SETTLE and SAMPLE.
REQ-022 start while busy SHALL be ignored with no effect on the scan.
REQ-023 Latency: done SHALL rise at the edge 2**N_IN*(SETTLE+1)+1 after the edge that accepted start (N_IN=2, SETTLE=1: edge 9).
REQ-024 resp SHALL be sampled only in SAMPLE; resp changes during SETTLE SHALL have no effect.
REQ-025 count SHALL never exceed 2**N_IN; its width covers the all-true case.

Reset
REQ-026 rst_n low SHALL asynchronously force state=IDLE, stim=0, settle counter=0, minterms=0, count=0, busy=0, done=0, pass=0.
REQ-027 Reset asserted mid-scan SHALL abort the scan; after release the block SHALL wait in IDLE for start, with no partial results retained.

Structure
REQ-028 Shared package sop_pkg SHALL hold the FSM state enum and the constants SETTLE_MAX=15 and N_IN_MAX=4.
REQ-029 The settle wait SHALL be one sub-module, sop_settle_timer (clear, enable, expired), instantiated once.

Verification
REQ-030 XOR: N_IN=2, SETTLE=1, resp=stim[1]^stim[0], expected=4'b0110, pulse start -> minterms=4'b0110, count=2, pass=1, done at edge 9.
REQ-031 AND: resp=stim[1]&stim[0], expected=4'b0110 -> minterms=4'b1000, count=1, pass=0, done=1.
REQ-032 Majority, N_IN=3, SETTLE=2 -> minterms=8'b11101000, count=4, done at edge 25.
REQ-033 start held high for the entire scan -> a single scan only; busy falls at the DONE edge; a new start in DONE clears the results and rescans.
REQ-034 rst_n pulsed low while stim=2 -> all outputs 0 immediately; no activity until the next start; the next scan completes normally.
REQ-035 resp toggled during SETTLE but stable in SAMPLE -> captured bits match the SAMPLE-cycle values only.
